// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART blocks
package uart_pkg;
    localparam int unsigned DEF_CLK_HZ = 68000000;
    localparam int unsigned DEF_BAUD = 115200;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned ACC_W = 28;
    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP      = 3'd4
    } state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: fractional accumulator producing RATE ticks per second from a CLK_HZ clock
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ,
    parameter int unsigned RATE = OVERSAMPLE * DEF_BAUD
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_sum;
    assign w_sum = r_acc + ACC_W'(RATE);
    assign o_tick = !i_clr && (w_sum >= ACC_W'(CLK_HZ));
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr)
            r_acc <= '0;
        else
            r_acc <= o_tick ? w_sum - ACC_W'(CLK_HZ) : w_sum;
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 16x oversampling, mid-bit sampling and framing-error detection
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ,
    parameter int unsigned BAUD = DEF_BAUD
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       uart_rx_i,
    output logic [7:0] uart_dat_o,
    output logic       uart_valid_o,
    output logic       uart_frame_err_o,
    output logic       uart_busy_o
);
    logic       r_sync1;
    logic       r_rx_s;
    logic [1:0] r_flush;
    state_t     r_state;
    logic [3:0] r_cnt;
    logic [2:0] r_idx;
    logic [7:0] r_shift;
    logic [7:0] r_dat;
    logic       r_valid;
    logic       r_ferr;
    logic       w_tick;
    logic       w_clr;

    assign w_clr = (r_state == ST_IDLE) || (r_state == ST_WAIT_IDLE);
    assign uart_dat_o = r_dat;
    assign uart_valid_o = r_valid;
    assign uart_frame_err_o = r_ferr;
    assign uart_busy_o = r_state != ST_IDLE;

    uart_baud_tick #(
        .CLK_HZ(CLK_HZ),
        .RATE  (OVERSAMPLE * BAUD)
    ) u_tick (
        .i_clk (sys_clk_i),
        .i_rst (sys_rst_i),
        .i_clr (w_clr),
        .o_tick(w_tick)
    );

    // r_flush keeps WAIT_IDLE from trusting the synchronizer's reset value of 1
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_flush <= 2'b00;
        end else begin
            r_sync1 <= uart_rx_i;
            r_rx_s  <= r_sync1;
            r_flush <= {r_flush[0], 1'b1};
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state <= ST_WAIT_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_dat   <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                ST_WAIT_IDLE: if (r_flush[1] && r_rx_s) r_state <= ST_IDLE;
                ST_IDLE: if (!r_rx_s) begin
                    r_state <= ST_START;
                    r_cnt   <= '0;
                end
                ST_START: if (w_tick) begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd7) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= r_rx_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: if (w_tick) begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_shift[r_idx] <= r_rx_s;
                        r_idx <= r_idx + 3'd1;
                        if (r_idx == 3'd7) r_state <= ST_STOP;
                    end
                end
                ST_STOP: if (w_tick) begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        if (r_rx_s) begin
                            r_dat   <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= ST_WAIT_IDLE;
                        end
                    end
                end
                default: r_state <= ST_WAIT_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed stimulus with a scoreboard of expected receive events
`timescale 1ns/1ps
module tb_uart_rx;
    typedef struct {
        logic        err;
        logic [7:0]  dat;
        int unsigned t0;
        logic        chk_lat;
    } exp_t;

    localparam real BT = 1.0e9 / 115200.0;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [7:0]  dat;
    logic        valid;
    logic        ferr;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned n_valid = 0;
    int unsigned n_ferr = 0;
    int unsigned t_prev = 0;
    int unsigned t_last = 0;
    int unsigned lat;
    logic [7:0]  last_dat = 8'h00;
    exp_t        q[$];
    exp_t        m_e;

    always #7.353 clk = ~clk;

    uart_rx dut (
        .sys_clk_i       (clk),
        .sys_rst_i       (rst),
        .uart_rx_i       (rx),
        .uart_dat_o      (dat),
        .uart_valid_o    (valid),
        .uart_frame_err_o(ferr),
        .uart_busy_o     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (valid || ferr) begin
            check("pulse_exclusive", {31'd0, valid && ferr}, 32'd0);
            check("pulse_expected", {31'd0, q.size() > 0}, 32'd1);
            if (q.size() > 0) begin
                m_e = q.pop_front();
                check("pulse_kind_ferr", {31'd0, ferr}, {31'd0, m_e.err});
                check("pulse_dat", {24'd0, dat}, {24'd0, m_e.dat});
                if (m_e.chk_lat) begin
                    lat = cyc - m_e.t0;
                    checks++;
                    assert (lat inside {[5570:5650]}) else begin
                        errors++;
                        $error("FAIL latency: observed %0d expected 5610+-40", lat);
                    end
                end
            end
            if (valid) begin
                n_valid++;
                t_prev = t_last;
                t_last = cyc;
            end else begin
                n_ferr++;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic stop, input real bt, input logic chk);
        exp_t e;
        e.err = !stop;
        e.dat = stop ? d : last_dat;
        e.t0 = cyc;
        e.chk_lat = chk;
        q.push_back(e);
        if (stop) last_dat = d;
        rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bt);
        end
        rx = stop;
        #(bt);
    endtask

    task automatic drain(input int unsigned lim);
        int unsigned n = 0;
        while (q.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", q.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_ferr", {31'd0, ferr}, 32'd0);
        check("rst_dat", {24'd0, dat}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_after_2", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("busy_after_3", {31'd0, busy}, 32'd0);
        repeat (2000) @(negedge clk);
        check("idle_no_valid", n_valid, 32'd0);
        check("idle_no_ferr", n_ferr, 32'd0);

        send(8'h55, 1'b1, BT, 1'b1);
        drain(8000);
        check("n_valid_55", n_valid, 32'd1);
        check("dat_55", {24'd0, dat}, 32'h55);

        send(8'hA3, 1'b1, BT, 1'b1);
        send(8'h00, 1'b1, BT, 1'b1);
        drain(8000);
        check("n_valid_b2b", n_valid, 32'd3);
        checks++;
        assert ((t_last - t_prev) inside {[5863:5943]}) else begin
            errors++;
            $error("FAIL b2b_gap: observed %0d expected 5903+-40", t_last - t_prev);
        end

        rx = 1'b0;
        repeat (200) @(negedge clk);
        rx = 1'b1;
        repeat (130) @(negedge clk);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        #(BT * 12.0);
        check("glitch_no_valid", n_valid, 32'd3);
        check("glitch_no_ferr", n_ferr, 32'd0);

        send(8'h3C, 1'b0, BT, 1'b1);
        #(BT * 2.0);
        check("break_busy", {31'd0, busy}, 32'd1);
        check("break_one_ferr", n_ferr, 32'd1);
        check("break_dat_kept", {24'd0, dat}, 32'h00);
        rx = 1'b1;
        #(BT);
        check("break_busy_released", {31'd0, busy}, 32'd0);
        send(8'h81, 1'b1, BT, 1'b1);
        drain(8000);
        check("dat_81", {24'd0, dat}, 32'h81);
        check("n_ferr_81", n_ferr, 32'd1);

        rx = 1'b0;
        #(BT);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b0;
            #(BT);
        end
        #(BT * 0.5);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        last_dat = 8'h00;
        check("midrst_dat", {24'd0, dat}, {24'd0, last_dat});
        check("midrst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #(BT);
        check("lowhold_busy", {31'd0, busy}, 32'd1);
        check("lowhold_no_valid", n_valid, 32'd4);
        rx = 1'b1;
        #(BT);
        send(8'h7E, 1'b1, BT / 1.03, 1'b0);
        drain(8000);
        check("dat_7e", {24'd0, dat}, 32'h7E);
        check("final_n_valid", n_valid, 32'd5);
        check("final_n_ferr", n_ferr, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
